flit_arbiter: RTL

//  Round-robin N:1 flit arbiter with a registered output stage. Sits directly upstream of

---
 rtl/flit_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/flit_arbiter.sv
// Round-robin N:1 flit arbiter with a registered output stage, feeding flit_queue.
// Optional per-input grant counters are enabled with the FLIT_ARBITER_STATS_EN macro.

package types;

    typedef struct packed {
        logic [7:0] src_id;
        logic [7:0] dst_id;
        logic [7:0] seq;
    } flit_header_t;

    typedef struct packed {
        flit_header_t header;
        logic [31:0]  payload;
    } flit_t;

endpackage

module flit_arbiter #(
    parameter int NUM_INPUTS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  types::flit_t [NUM_INPUTS-1:0]    in_flit,
    input  logic         [NUM_INPUTS-1:0]    in_flit_valid,
    output logic         [NUM_INPUTS-1:0]    in_flit_ready,
    output types::flit_t                     out_flit,
    output logic                             out_flit_valid,
    input  logic                             out_flit_ready
`ifdef FLIT_ARBITER_STATS_EN
    ,
    output logic         [NUM_INPUTS-1:0][15:0] grant_count
`endif
);

    localparam int PTR_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int PAD_N    = 1 << PTR_W;

    logic [PTR_W-1:0]             rr_ptr;
    logic [PTR_W-1:0]             grant_idx;
    logic                         grant_found;
    logic                         load_en;
    logic [PAD_N-1:0]             valid_pad;
    types::flit_t [PAD_N-1:0]     flit_pad;
    logic [PTR_W:0]               cand;

    assign load_en = !out_flit_valid || out_flit_ready;

    // Inputs are padded to a power-of-two count so the pointer indexes them at exact width.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        valid_pad = '0;
        flit_pad  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            valid_pad[i] = in_flit_valid[i];
            flit_pad[i]  = in_flit[i];
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_INPUTS))
                cand = cand - (PTR_W+1)'(NUM_INPUTS);
            if (!grant_found && valid_pad[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Gated by rst_n so no input sees an accept while the block is held in reset.
    assign in_flit_ready = (rst_n && load_en && grant_found)
                         ? (NUM_INPUTS'(1) << grant_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_flit       <= '0;
            out_flit_valid <= 1'b0;
            rr_ptr         <= '0;
        end else if (load_en) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (grant_found) begin
                out_flit       <= flit_pad[grant_idx];
                out_flit_valid <= 1'b1;
                rr_ptr         <= (grant_idx == PTR_W'(NUM_INPUTS - 1)) ? '0
                                                                        : grant_idx + PTR_W'(1);
            end else begin
                out_flit_valid <= 1'b0;
            end
        end
    end

`ifdef FLIT_ARBITER_STATS_EN
    // Saturating counters; observation only, never fed back into arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count <= '0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (in_flit_valid[i] && in_flit_ready[i] && grant_count[i] != 16'hFFFF)
                    grant_count[i] <= grant_count[i] + 16'd1;
            end
        end
    end
`endif

endmodule
